// File: rtl/clock_set_ctrl.sv
// HH:MM time-keeping and time-setting controller: debounced mode/inc buttons,
// RUN/SET_HH/SET_MM mode FSM, BCD digit registers and blink mask for the scan stage.
module clock_set_ctrl #(
   parameter int DEB_CYCLES = 20,
   parameter int DEB_W      = 5,
   parameter int BLINK_DIV  = 250,
   parameter int BLINK_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] DATA0,
   output logic [3:0] DATA1,
   output logic [3:0] DATA2,
   output logic [3:0] DATA3,
   output logic [3:0] blank,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      SET_HH = 2'b01,
      SET_MM = 2'b10
   } state_t;

   localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

   // Index 0 = mode button, index 1 = inc button.
   logic [1:0]            sync1_q, sync2_q, acc_q;
   logic [1:0]            acc_d;
   logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [1:0]            press;

   state_t               state_q, state_d;
   logic [3:0]           min_u_q, min_t_q, hr_u_q, hr_t_q;
   logic [3:0]           min_u_d, min_t_d, hr_u_d, hr_t_d;
   logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
   logic                 phase_q, phase_d;
   logic [3:0]           blank_q, blank_d;

   logic p_mode, p_inc;
   logic min_wrap;

   assign p_mode = press[0];
   assign p_inc  = press[1];

   always_comb begin
      // NOTE: every _d gets a default first, so no path through this block can infer a latch.
      acc_d       = acc_q;
      deb_cnt_d   = deb_cnt_q;
      press       = 2'b00;
      state_d     = state_q;
      min_u_d     = min_u_q;
      min_t_d     = min_t_q;
      hr_u_d      = hr_u_q;
      hr_t_d      = hr_t_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      blank_d     = 4'b0000;
      min_wrap    = 1'b0;

      // Accept a new level only after it has differed from the accepted one DEB_CYCLES times in a row.
      for (int b = 0; b < 2; b++) begin
         if (sync2_q[b] == acc_q[b]) begin
            deb_cnt_d[b] = '0;
         end else if (deb_cnt_q[b] == DEB_MAX) begin
            deb_cnt_d[b] = '0;
            acc_d[b]     = sync2_q[b];
            press[b]     = sync2_q[b];
         end else begin
            deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
         end
      end

      if (p_mode) begin
         unique case (state_q)
            RUN:     state_d = SET_HH;
            SET_HH:  state_d = SET_MM;
            default: state_d = RUN;
         endcase
      end

      if (state_q == RUN && tick) begin
         if (min_u_q == 4'd9) begin
            min_u_d = 4'd0;
            if (min_t_q == 4'd5) begin
               min_t_d  = 4'd0;
               min_wrap = 1'b1;
            end else begin
               min_t_d = min_t_q + 4'd1;
            end
         end else begin
            min_u_d = min_u_q + 4'd1;
         end
      end else if (state_q == SET_MM && p_inc && !p_mode) begin
         // Minutes wrap 59 -> 00 here without touching the hours.
         if (min_u_q == 4'd9) begin
            min_u_d = 4'd0;
            min_t_d = (min_t_q == 4'd5) ? 4'd0 : min_t_q + 4'd1;
         end else begin
            min_u_d = min_u_q + 4'd1;
         end
      end

      if (min_wrap || (state_q == SET_HH && p_inc && !p_mode)) begin
         if (hr_t_q == 4'd2 && hr_u_q == 4'd3) begin
            hr_t_d = 4'd0;
            hr_u_d = 4'd0;
         end else if (hr_u_q == 4'd9) begin
            hr_u_d = 4'd0;
            hr_t_d = hr_t_q + 4'd1;
         end else begin
            hr_u_d = hr_u_q + 4'd1;
         end
      end

      if (state_d == RUN) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (state_q != RUN) begin
         if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end

      unique case (state_d)
         SET_HH:  blank_d = {phase_d, phase_d, 2'b00};
         SET_MM:  blank_d = {2'b00, phase_d, phase_d};
         default: blank_d = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         acc_q       <= '0;
         deb_cnt_q   <= '0;
         state_q     <= RUN;
         min_u_q     <= '0;
         min_t_q     <= '0;
         hr_u_q      <= '0;
         hr_t_q      <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         blank_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
         sync1_q     <= {btn_inc, btn_mode};
         sync2_q     <= sync1_q;
         acc_q       <= acc_d;
         deb_cnt_q   <= deb_cnt_d;
         state_q     <= state_d;
         min_u_q     <= min_u_d;
         min_t_q     <= min_t_d;
         hr_u_q      <= hr_u_d;
         hr_t_q      <= hr_t_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         blank_q     <= blank_d;
      end
   end

   assign DATA0 = min_u_q;
   assign DATA1 = min_t_q;
   assign DATA2 = hr_u_q;
   assign DATA3 = hr_t_q;
   assign blank = blank_q;
   assign mode  = state_q;

endmodule
